// File: rtl/addsub_seq.sv
// ---------------------------------------------------------------------------
// addsub_seq
//
// Sequential adder/subtractor. It processes CHUNK bits per clock, least
// significant chunk first, and uses WIDTH/CHUNK calculation cycles.
// Subtraction is done as a + ~b + 1: the operator bit inverts b and also
// supplies the initial carry-in.
//
// Optional feature (compile-time macro):
//   ADDSUB_SAT_EN  - when defined, the result saturates on overflow instead
//                    of wrapping. Carry and overflow flags are the same in
//                    both builds.
//
// Parameters:
//   WIDTH        operand/result width in bits (must be a multiple of CHUNK)
//   CHUNK        bits processed per clock
//
// Ports:
//   clk          clock, all state changes on the rising edge
//   n_rst        asynchronous active-low reset
//   a, b         operands, latched when a start is accepted
//   operator     0 = a+b, 1 = a-b
//   data_type    0 = unsigned, 1 = two's-complement signed
//   parser_done  start request, only looked at in IDLE
//   result       registered final result
//   alu_out      copy of result
//   alu_done     one-cycle completion pulse
//   busy         high while an operation is in flight (CALC or DONE)
//   carry        add carry-out, or sub borrow
//   overflow     unsigned carry/borrow, or signed overflow
// ---------------------------------------------------------------------------
module addsub_seq #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             operator,
    input  logic             data_type,
    input  logic             parser_done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] alu_out,
    output logic             alu_done,
    output logic             busy,
    output logic             carry,
    output logic             overflow
);

    // A CHUNK of zero must not break the division below before the check
    // gets a chance to report the bad configuration.
    localparam int SAFE_CHUNK = (CHUNK > 0) ? CHUNK : 1;
    localparam int N          = WIDTH / SAFE_CHUNK;
    localparam int IDX_W      = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    generate
        if ((CHUNK < 1) || ((WIDTH % SAFE_CHUNK) != 0)) begin : g_bad_chunk
            $error("addsub_seq: WIDTH (%0d) must be a multiple of CHUNK (%0d)",
                   WIDTH, CHUNK);
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           next_state;

    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             op_q;
    logic             dt_q;
    logic [IDX_W-1:0] idx;
    logic             c_q;
    logic [WIDTH-1:0] sum_q;

    logic [WIDTH-1:0] result_q;
    logic             carry_q;
    logic             overflow_q;
    logic             done_q;

    logic [CHUNK-1:0] a_chunk;
    logic [CHUNK-1:0] b_chunk;
    logic [CHUNK:0]   chunk_sum;
    logic [WIDTH-1:0] full_sum;
    logic             last_chunk;
    logic             carry_flag;
    logic             sign_a;
    logic             sign_b_eff;
    logic             signed_ovf;
    logic             ovf_flag;
    logic [WIDTH-1:0] final_result;

    // State register
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; parser_done is deliberately ignored outside IDLE so
    // a request arriving mid-operation is dropped, not queued.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (parser_done) next_state = CALC;
            CALC:    if (last_chunk)  next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // One chunk of the ripple sum per cycle. full_sum is the running sum
    // with the current chunk merged in, so on the last chunk it holds the
    // complete WIDTH-bit answer.
    always_comb begin
        a_chunk    = a_q[idx*CHUNK +: CHUNK];
        b_chunk    = b_q[idx*CHUNK +: CHUNK] ^ {CHUNK{op_q}};
        chunk_sum  = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, c_q};
        full_sum   = sum_q;
        full_sum[idx*CHUNK +: CHUNK] = chunk_sum[CHUNK-1:0];
        last_chunk = (idx == LAST_IDX);
    end

    // Final flags. For subtraction the carry-out of a + ~b + 1 is the
    // complement of the borrow. Signed overflow: operands of equal sign
    // (after b is inverted for subtract) giving a result of the other sign.
    always_comb begin
        carry_flag = chunk_sum[CHUNK] ^ op_q;
        sign_a     = a_q[WIDTH-1];
        sign_b_eff = b_q[WIDTH-1] ^ op_q;
        signed_ovf = (sign_a == sign_b_eff) && (full_sum[WIDTH-1] != sign_a);
        ovf_flag   = dt_q ? signed_ovf : carry_flag;
        final_result = full_sum;
`ifdef ADDSUB_SAT_EN
        // Signed overflow direction follows the sign of a: a positive a can
        // only overflow upward, a negative a only downward.
        if (ovf_flag) begin
            if (dt_q) begin
                final_result = sign_a ? {1'b1, {(WIDTH-1){1'b0}}}
                                      : {1'b0, {(WIDTH-1){1'b1}}};
            end else begin
                final_result = op_q ? {WIDTH{1'b0}} : {WIDTH{1'b1}};
            end
        end
`endif
    end

    // Operand latch, chunk walk and completion registers. Visible outputs
    // only change on the cycle that finishes the last chunk.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= 1'b0;
            dt_q       <= 1'b0;
            idx        <= '0;
            c_q        <= 1'b0;
            sum_q      <= '0;
            result_q   <= '0;
            carry_q    <= 1'b0;
            overflow_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (parser_done) begin
                        a_q   <= a;
                        b_q   <= b;
                        op_q  <= operator;
                        dt_q  <= data_type;
                        idx   <= '0;
                        c_q   <= operator;
                        sum_q <= '0;
                    end
                end
                CALC: begin
                    sum_q <= full_sum;
                    c_q   <= chunk_sum[CHUNK];
                    if (last_chunk) begin
                        idx        <= '0;
                        result_q   <= final_result;
                        carry_q    <= carry_flag;
                        overflow_q <= ovf_flag;
                        done_q     <= 1'b1;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign result   = result_q;
    assign alu_out  = result_q;
    assign alu_done = done_q;
    assign busy     = (state != IDLE);
    assign carry    = carry_q;
    assign overflow = overflow_q;

endmodule

// File: doc/addsub_seq.md
ADDSUB_SEQ -- requirements
Module: addsub_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand and result width in bits.
REQ-002 SHALL have parameter CHUNK, default 8: bits processed per clock; WIDTH SHALL be an integer multiple of CHUNK, and elaboration SHALL fail otherwise.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-004 SHALL have port n_rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port a, input, WIDTH bits: first operand.
REQ-006 SHALL have port b, input, WIDTH bits: second operand.
REQ-007 SHALL have port operator, input, 1 bit: 0 = a+b, 1 = a-b.
REQ-008 SHALL have port data_type, input, 1 bit: 0 = unsigned, 1 = two's-complement signed.
REQ-009 SHALL have port parser_done, input, 1 bit: start request, sampled only in IDLE.
REQ-010 SHALL have port result, output, WIDTH bits: registered final result.
REQ-011 SHALL have port alu_out, output, WIDTH bits: always equal to result.
REQ-012 SHALL have port alu_done, output, 1 bit: one-cycle completion pulse.
REQ-013 SHALL have port busy, output, 1 bit: high in CALC and DONE.
REQ-014 SHALL have port carry, output, 1 bit: add carry-out, or sub borrow (= inverted carry-out).
REQ-015 SHALL have port overflow, output, 1 bit: unsigned carry/borrow when data_type=0, signed overflow when data_type=1.

Function
REQ-016 SHALL implement FSM states IDLE, CALC, DONE.
REQ-017 SHALL, at a rising edge in IDLE with parser_done=1, latch a, b, operator, data_type, clear chunk index, set initial carry = operator, and enter CALC.
REQ-018 SHALL, in CALC, compute a chunk + (b chunk XOR operator) + carry on each edge, LSB chunk first, storing the chunk sum and propagating carry.
REQ-019 SHALL use N = WIDTH/CHUNK CALC edges; the edge computing chunk N-1 SHALL update result, carry and overflow, set alu_done=1 and enter DONE.
REQ-020 SHALL give latency N+1 edges from the start-sampling edge to the edge raising alu_done (5 edges for the defaults).
REQ-021 SHALL move DONE -> IDLE on the next edge and clear alu_done; alu_done is high exactly one cycle.
REQ-022 SHALL ignore parser_done in CALC and DONE, with no queuing; the earliest restart is the first IDLE cycle.
REQ-023 SHALL change result, alu_out, carry and overflow only at completion, holding them until the next completion.
REQ-024 SHALL compute signed overflow as (sign a == sign of effective b) AND (sign result != sign a).
REQ-025 SHALL keep operand changes after latching from affecting the operation in progress.

Reset
REQ-026 SHALL, while n_rst=0, immediately force IDLE and drive result, alu_out, alu_done, busy, carry, overflow and all internal registers to 0, including mid-operation.
REQ-027 SHALL, after n_rst deasserts, accept parser_done on the first clock edge.

Configuration
REQ-028 SHALL, when macro ADDSUB_SAT_EN is defined, clamp result on overflow: signed to 0x7F..F or 0x80..0 by direction; unsigned add to all ones; unsigned sub to 0.
REQ-029 SHALL, when ADDSUB_SAT_EN is undefined, wrap result modulo 2^WIDTH; carry and overflow SHALL be reported identically in both builds.

Verification
REQ-030 SHALL cover: defaults, unsigned, sub, a=5, b=3 -> result=2, carry=0, overflow=0; alu_done 5 edges after start, high one cycle.
REQ-031 SHALL cover: unsigned sub, a=3, b=5 -> carry=1, overflow=1; result=0xFFFFFFFE without SAT, 0x00000000 with ADDSUB_SAT_EN.
REQ-032 SHALL cover: signed add, a=0x7FFFFFFF, b=1 -> overflow=1; result=0x80000000 without SAT, 0x7FFFFFFF with SAT.
REQ-033 SHALL cover: parser_done held high through CALC with new operands -> exactly one alu_done pulse and result from the first operands; a second pulse only after returning to IDLE.
REQ-034 SHALL cover: n_rst asserted at CALC edge 2 -> all outputs 0 asynchronously, no alu_done pulse; a new start completes correctly.
REQ-035 SHALL cover: WIDTH=16, CHUNK=4, add a=0xFFFF, b=1 -> result=0x0000, carry=1, alu_done 5 edges after start.
